// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and arbitration helper for the four-requester mux arbiter.
// Latency: none (types, constants and a pure combinational function).
// Backpressure: not applicable; the function only ranks requests against the pointer.
package mux4_arb_pkg;

    localparam int NREQ  = 4;
    localparam int PTR_W = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Result of a priority search: winner index and whether anyone requested.
    typedef struct packed {
        logic             found;
        logic [PTR_W-1:0] idx;
    } pick_t;

    // Search req in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4); first set bit wins.
    // The loop walks from the farthest offset back to the nearest so the
    // nearest asserted request is the last one written and therefore wins.
    function automatic pick_t rr_pick(input logic [NREQ-1:0]  req,
                                      input logic [PTR_W-1:0] ptr);
        pick_t            p;
        logic [PTR_W-1:0] cand;
        p = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = ptr + PTR_W'(k);
            if (req[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_datapath.sv
// Bit-sliced word mux: WIDTH mux4to1 instances select the granted requester's word.
// Latency: combinational from din and the registered select.
// Backpressure: none here; the output is forced to zero whenever out_valid is low.
module mux4_rr_arbiter_datapath
    import mux4_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [NREQ*WIDTH-1:0] din,
    input  logic [PTR_W-1:0]      sel,
    input  logic                  out_valid,
    output logic [WIDTH-1:0]      out_data
);

    logic [WIDTH-1:0] mux_bits;

    // One mux4to1 per bit position; lane i of d carries bit b of requester i.
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [NREQ-1:0] d_bits;
        for (genvar i = 0; i < NREQ; i++) begin : g_req
            assign d_bits[i] = din[i*WIDTH + b];
        end
        mux4to1 u_mux (
            .d   (d_bits),
            .sel (sel),
            .y   (mux_bits[b])
        );
    end

    // Gate with out_valid so the word reads as zero while idle.
    assign out_data = mux_bits & {WIDTH{out_valid}};

endmodule

// File: rtl/mux4to1.sv
// Existing single-bit 4-to-1 multiplexer used as the datapath building block.
// Latency: purely combinational.
// Backpressure: none; output follows d and sel continuously.
module mux4to1 (
    input  logic [3:0] d,
    input  logic [1:0] sel,
    output logic       y
);

    assign y = d[sel];

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin (or fixed-priority with MUX4_ARB_FIXED_PRIO_EN) arbiter sharing one mux among four requesters.
// Latency: one cycle from request sampled in IDLE to gnt/sel/out_valid; back-to-back beats thereafter.
// Backpressure: a granted beat holds gnt/sel/out_valid until out_ready; ack = gnt & out_ready.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] din,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic [PTR_W-1:0]      sel,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    input  logic                  out_ready
);

`ifdef MUX4_ARB_FIXED_PRIO_EN
    localparam logic FIXED_PRIO = 1'b1;
`else
    localparam logic FIXED_PRIO = 1'b0;
`endif

    state_t           state;
    logic [PTR_W-1:0] ptr;
    pick_t            pick;

    // Winner for the next grant, ranked against the current pointer.
    always_comb begin
        pick = rr_pick(req, ptr);
    end

    // Arbitration FSM: grants in IDLE, re-arbitrates on each completed beat in GRANT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            sel       <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick.found) begin
                        state     <= GRANT;
                        gnt       <= NREQ'(1) << pick.idx;
                        sel       <= pick.idx;
                        out_valid <= 1'b1;
                        ptr       <= FIXED_PRIO ? '0 : pick.idx + 1'b1;
                    end
                end
                GRANT: begin
                    // Nothing moves while the beat is backpressured.
                    if (out_ready) begin
                        if (pick.found) begin
                            gnt <= NREQ'(1) << pick.idx;
                            sel <= pick.idx;
                            ptr <= FIXED_PRIO ? '0 : pick.idx + 1'b1;
                        end else begin
                            // sel keeps the last winner while idle.
                            state     <= IDLE;
                            gnt       <= '0;
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= '0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // The accepted beat is acknowledged to its owner in the handshake cycle.
    assign ack = gnt & {NREQ{out_ready}};

    mux4_rr_arbiter_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .din       (din),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    // Grant is never more than one requester at a time.
    a_gnt_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

    // A stalled beat keeps its grant, select and valid.
    a_hold : assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(gnt) && $stable(sel)));

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus randomized traffic against a reference model.
// Latency: model expects grant one cycle after a request is sampled in idle.
// Backpressure: out_ready is randomized; model holds the beat until accepted.
module tb_mux4_rr_arbiter;

    localparam int W = 8;

`ifdef MUX4_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     req;
    logic [4*W-1:0] din;
    logic [3:0]     gnt;
    logic [3:0]     ack;
    logic [1:0]     sel;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_ready;

    mux4_rr_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din       (din),
        .gnt       (gnt),
        .ack       (ack),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: is a beat outstanding, whose it is, where the search starts next.
    bit m_busy = 1'b0;
    int m_sel  = 0;
    int m_ptr  = 0;

    logic [3:0] last_ack;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] lane(input logic [4*W-1:0] d, input int i);
        return d[i*W +: W];
    endfunction

    function automatic logic [4*W-1:0] mk_din(input logic [W-1:0] a0, input logic [W-1:0] a1,
                                              input logic [W-1:0] a2, input logic [W-1:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        int  winner;
        bit  found;
        if (rst) begin
            m_busy = 1'b0;
            m_sel  = 0;
            m_ptr  = 0;
        end else if (!m_busy || out_ready) begin
            found  = 1'b0;
            winner = 0;
            for (int k = 0; k < 4; k++) begin
                if (!found && req[(m_ptr + k) % 4]) begin
                    found  = 1'b1;
                    winner = (m_ptr + k) % 4;
                end
            end
            if (found) begin
                m_busy = 1'b1;
                m_sel  = winner;
                m_ptr  = FIXED ? 0 : (winner + 1) % 4;
            end else begin
                m_busy = 1'b0;
            end
        end
    endtask

    // Drive one cycle of inputs, check the handshake-cycle outputs, then the post-edge state.
    task automatic run_cycle(input logic r, input logic [3:0] rq, input logic rdy,
                             input logic [4*W-1:0] d);
        @(negedge clk);
        rst       = r;
        req       = rq;
        out_ready = rdy;
        din       = d;
        #1;
        last_ack = ack;
        check_val("ack", ack, (m_busy && rdy) ? (32'(1) << m_sel) : 32'(0));
        check_val("data_live", out_data, m_busy ? lane(din, m_sel) : '0);
        @(posedge clk);
        model_step();
        #1;
        check_val("gnt", gnt, m_busy ? (32'(1) << m_sel) : 32'(0));
        check_val("sel", sel, m_sel);
        check_val("out_valid", out_valid, m_busy);
        check_val("out_data", out_data, m_busy ? lane(din, m_sel) : '0);
    endtask

    logic [4*W-1:0] dd;
    logic [4*W-1:0] d_cur;
    logic [3:0]     rq_cur;
    int             ack3_cnt;

    initial begin
        rst       = 1'b1;
        req       = 4'b1111;
        din       = '0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        dd = mk_din(8'h11, 8'h22, 8'h33, 8'h44);

        // Reset held with all requests up, then first grant and rotation.
        run_cycle(1'b1, 4'b1111, 1'b1, dd);
        run_cycle(1'b1, 4'b1111, 1'b1, dd);
        run_cycle(1'b0, 4'b1111, 1'b1, dd);
        check_val("first_winner", gnt, 4'b0001);
        for (int i = 1; i < 8; i++) begin
            run_cycle(1'b0, 4'b1111, 1'b1, dd);
            check_val("rotation_sel", sel, FIXED ? 0 : i % 4);
            check_val("rotation_ack", last_ack, 32'(1) << (FIXED ? 0 : (i - 1) % 4));
        end

        // Single requester, dropped in its ack cycle.
        run_cycle(1'b1, 4'b0000, 1'b0, dd);
        dd = mk_din(8'h00, 8'h00, 8'hA5, 8'h00);
        run_cycle(1'b0, 4'b0100, 1'b1, dd);
        check_val("single_gnt", gnt, 4'b0100);
        check_val("single_sel", sel, 2);
        check_val("single_data", out_data, 8'hA5);
        run_cycle(1'b0, 4'b0000, 1'b1, dd);
        check_val("single_ack", last_ack, 4'b0100);
        check_val("single_idle", out_valid, 1'b0);

        // Backpressure on requester 1 while requester 3 arrives.
        run_cycle(1'b1, 4'b0000, 1'b0, dd);
        dd = mk_din(8'h10, 8'h5C, 8'h30, 8'hE7);
        run_cycle(1'b0, 4'b0010, 1'b0, dd);
        for (int i = 0; i < 5; i++) begin
            run_cycle(1'b0, 4'b1010, 1'b0, dd);
            check_val("bp_gnt", gnt, 4'b0010);
            check_val("bp_data", out_data, 8'h5C);
        end
        run_cycle(1'b0, 4'b1000, 1'b1, dd);
        check_val("bp_ack", last_ack, 4'b0010);
        check_val("bp_next_gnt", gnt, 4'b1000);
        run_cycle(1'b0, 4'b0000, 1'b1, dd);

        // Pointer wrap after requester 3.
        run_cycle(1'b1, 4'b0000, 1'b0, dd);
        run_cycle(1'b0, 4'b1000, 1'b1, dd);
        check_val("wrap_first", sel, 3);
        run_cycle(1'b0, 4'b1001, 1'b1, dd);
        check_val("wrap_sel", sel, 0);
        run_cycle(1'b0, 4'b1000, 1'b1, dd);
        check_val("wrap_then3", sel, 3);
        run_cycle(1'b0, 4'b0000, 1'b1, dd);

        // Two contenders held: fixed priority starves 3, round robin alternates.
        run_cycle(1'b1, 4'b0000, 1'b0, dd);
        ack3_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            run_cycle(1'b0, 4'b1001, 1'b1, dd);
            if (last_ack[3]) ack3_cnt++;
        end
        check_val("prio_ack3", ack3_cnt, FIXED ? 0 : 1);
        check_val("prio_sel", sel, FIXED ? 0 : 3);

        // Reset while a beat is stalled.
        run_cycle(1'b0, 4'b0100, 1'b0, dd);
        run_cycle(1'b0, 4'b0100, 1'b0, dd);
        check_val("pre_rst_valid", out_valid, 1'b1);
        run_cycle(1'b1, 4'b0100, 1'b0, dd);
        check_val("rst_gnt", gnt, 4'b0000);
        check_val("rst_sel", sel, 0);
        check_val("rst_valid", out_valid, 1'b0);
        check_val("rst_data", out_data, 8'h00);
        run_cycle(1'b1, 4'b0000, 1'b0, dd);

        // Randomized traffic following the hold-until-ack protocol.
        rq_cur = '0;
        d_cur  = '0;
        for (int n = 0; n < 2000; n++) begin
            logic r;
            logic rdy;
            int   acked;
            r     = ($urandom_range(0, 99) == 0);
            rdy   = ($urandom_range(0, 2) != 0);
            acked = (m_busy && rdy) ? m_sel : -1;
            for (int i = 0; i < 4; i++) begin
                if (rq_cur[i]) begin
                    if (i == acked && $urandom_range(0, 1) == 0)
                        rq_cur[i] = 1'b0;
                    else if ($urandom_range(0, 49) == 0)
                        rq_cur[i] = 1'b0;
                end else begin
                    d_cur[i*W +: W] = W'($urandom);
                    if ($urandom_range(0, 2) == 0) rq_cur[i] = 1'b1;
                end
            end
            run_cycle(r, rq_cur, rdy, d_cur);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares one 4-to-1 multiplexer datapath between four requesters. Each requester presents a request and a WIDTH-bit word. The block selects one winner at a time, drives the mux select and presents the chosen word on a valid/ready output channel. It sits in front of the existing `mux4to1` datapath and replaces hand-driven `sel` with sequenced, fair access.

## Interface
- `WIDTH`, default 8: data width per requester and on the output.
- `clk`  input  1  rising-edge clock; the only clock.
- `rst`  input  1  synchronous, active-high reset.
- `req`  input  4  per-requester request; bit i belongs to requester i.
- `din`  input  4*WIDTH  requester data; requester i occupies bits `[i*WIDTH +: WIDTH]`.
- `gnt`  output  4  one-hot registered grant; all zero when idle.
- `ack`  output  4  one-hot ack for the accepted beat: `gnt & {4{out_ready}}`.
- `sel`  output  2  registered mux select (index of current or last winner).
- `out_valid`  output  1  output word valid.
- `out_data`  output  WIDTH  selected word.
- `out_ready`  input  1  downstream accepts the beat when high together with `out_valid`.

## Operation
- States: IDLE and GRANT.
- IDLE: if `req != 0`, choose a winner, register `gnt` and `sel`, then go to GRANT. Otherwise stay in IDLE.
- GRANT: `out_valid = 1`, `out_data = din[sel]`. The transfer completes on the clock edge where `out_ready = 1`.
- On completion, re-arbitrate in the same cycle:
  - If any request is pending, grant the next winner and stay in GRANT.
  - Else return to IDLE.
- Each grant carries exactly one beat.
- Round-robin search order is `ptr, ptr+1, ptr+2, ptr+3` mod 4. The first asserted `req` in that order wins.
- After a grant to requester i, `ptr = (i+1) mod 4`, so requester 3 wraps to 0.
- A requester holds `req` and its `din` stable from assertion until it sees its `ack` bit.
- Dropping `req` while granted does not cancel the beat. The grant still completes on `out_ready`, with `out_data` following live `din[sel]`.
- `out_valid`, `gnt` and `sel` do not change while `out_valid && !out_ready`. A backpressured beat is held indefinitely and never aborted.
- In IDLE, `out_data = 0` and `out_valid = 0`.
- Reset values: state IDLE, `gnt = 0`, `sel = 0`, `out_valid = 0`, `out_data = 0`, `ptr = 0`.

## Timing
- Grant latency: `req` sampled high at edge N (from IDLE) gives `gnt`, `sel` and `out_valid` high after edge N, i.e. one cycle.
- Throughput: with `out_ready` held high and requests pending, one beat per cycle, with the grant moving each cycle.
- Fairness: with all four `req` held high, the grant order is 0,1,2,3,0,1,...
- A newly arriving request loses to an already-pending request that comes earlier in search order.
- `ack` is combinational from the registered `gnt` and `out_ready`, and is valid in the same cycle as the handshake.
- `rst` high at any edge, including mid-GRANT under backpressure, forces the reset values at that edge. The in-flight beat is dropped without `ack`.
- `rst` wins over every other event in the same cycle.

## Configuration
- `MUX4_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, requester 0 highest and 3 lowest. `ptr` is held at 0 and never updated. Requester 3 can starve.
  - Undefined (default): the round-robin behaviour described above.
- The ports and timing are identical in both builds.

## Structure
- Package `mux4_arb_pkg` holds:
  - the state enum (IDLE, GRANT),
  - `NREQ = 4`,
  - `PTR_W = 2`,
  - the rotate/priority-pick function, which returns the winner index and a found flag from `req` and `ptr`.
- Sub-module: the datapath is a generate loop of WIDTH instances of the existing `mux4to1`.
  - Bit b of each requester forms `d`, the registered `sel` drives `sel`, and `y` is out_data bit b.
  - A final AND with `out_valid` gives the zero-when-idle output.
- All state lives in the top; there is no second sub-module.

## Test plan
- **Reset/idle:** assert `rst` 2 cycles with `req = 4'b1111` -> `gnt = 0`, `sel = 0`, `out_valid = 0` throughout. After release, the first grant goes to requester 0.
- **Single requester:** `req = 4'b0100`, `din[2] = 8'hA5`, `out_ready = 1` -> one cycle later `gnt = 4'b0100`, `sel = 2`, `out_data = 8'hA5`, `ack[2] = 1`. Drop `req` -> IDLE next cycle.
- **Fair rotation:** `req = 4'b1111`, `out_ready = 1` for 8 cycles -> `sel` sequence 0,1,2,3,0,1,2,3, one `ack` per cycle.
- **Backpressure:** requester 1 granted with `out_ready = 0` for 5 cycles while `req[3]` also rises -> `gnt = 4'b0010` and `out_data` stable for 5 cycles. Raise `out_ready` -> `ack[1]`, then `gnt = 4'b1000` next cycle.
- **Wrap/pointer:** after a grant to requester 3, set `req = 4'b1001` -> requester 0 wins before 3.
- **Fixed priority (`MUX4_ARB_FIXED_PRIO_EN` defined):** `req = 4'b1001` held for 4 cycles -> requester 0 granted every beat, `ack[3]` never asserted. Separately, `rst` mid-GRANT -> outputs at reset values at that edge.
